aes_stream_if: RTL and testbench

- Streaming front/back end for the 10-round AES-128 cipher pipeline.
- Upstream: packs 32-bit words from a valid/ready stream into a 128-bit key register and 128-bit plaintext blocks, then issues each block into the non-stallable cipher pipeline.
- Downstream: tracks pipeline latency with a valid shift register, captures each ciphertext into a block FIFO, and serializes it as 32-bit words.
- Credit logic guarantees no ciphertext is ever lost, because the cipher cannot stall.

---
 rtl/aes_stream_pkg.sv | 30 +++
 rtl/aes_blk_fifo.sv | 114 +++++++++++
 rtl/aes_stream_if.sv | 183 ++++++++++++++++++
 tb/tb_aes_stream_if.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_stream_pkg.sv
// -----------------------------------------------------------------------------
// aes_stream_pkg
// Shared widths, types and helpers for the AES-128 streaming front/back end.
//   WORD_W        : stream word width (32)
//   BLK_W         : cipher block / key width (128)
//   WORDS_PER_BLK : stream words per block (4)
//   word_idx_t    : index of a word inside a block
//   grp_e         : type of the group currently being packed
//   cred_w()      : width needed to hold a credit count of 0..depth
// -----------------------------------------------------------------------------
package aes_stream_pkg;

  localparam int WORD_W        = 32;
  localparam int BLK_W         = 128;
  localparam int WORDS_PER_BLK = 4;

  typedef logic [1:0] word_idx_t;

  localparam word_idx_t LAST_WORD = word_idx_t'(WORDS_PER_BLK - 1);

  typedef enum logic {
    GRP_DATA = 1'b0,
    GRP_KEY  = 1'b1
  } grp_e;

  function automatic int cred_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// -----------------------------------------------------------------------------
// aes_blk_fifo
// Synchronous DEPTH x 128-bit block FIFO with synchronous active-high reset.
// The head entry is presented combinationally from the storage array.
//   clk, rst  : clock, synchronous active-high reset
//   push_i    : write data_i (ignored when full)
//   data_i    : block to write
//   pop_i     : drop the head entry (ignored when empty)
//   data_o    : head entry
//   empty_o   : no entries stored
//   full_o    : DEPTH entries stored
// aes_blk_fifo_chk holds the simulation-only overflow assertion.
// -----------------------------------------------------------------------------
module aes_blk_fifo
  import aes_stream_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [BLK_W-1:0] data_i,
  input  logic             pop_i,
  output logic [BLK_W-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cred_w(DEPTH);

  logic [BLK_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_s, pop_s;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? {AW{1'b0}} : p + AW'(1);
  endfunction

  assign empty_o = (cnt_q == {CW{1'b0}});
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign data_o  = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy.
  always_comb begin
    push_s   = push_i & ~full_o;
    pop_s    = pop_i & ~empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  aes_blk_fifo_chk u_chk (
    .clk    (clk),
    .rst    (rst),
    .push_i (push_i),
    .full_i (full_o)
  );

endmodule

// -----------------------------------------------------------------------------
// aes_blk_fifo_chk
// Simulation checker: the cipher cannot stall, so a write into a full FIFO
// would silently drop a ciphertext. Credit logic upstream must prevent it.
// -----------------------------------------------------------------------------
module aes_blk_fifo_chk (
  input logic clk,
  input logic rst,
  input logic push_i,
  input logic full_i
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push_i && full_i));

endmodule

// File: rtl/aes_stream_if.sv
// -----------------------------------------------------------------------------
// aes_stream_if
// Streaming wrapper around a non-stallable LAT-deep AES-128 pipeline.
// Packs 32-bit words into key/plaintext blocks, issues blocks into the cipher,
// tracks latency with a valid shift register, buffers ciphertexts in a FIFO
// and serialises them back out as 32-bit words. Credits bound blocks in flight
// plus buffered to DEPTH so a ciphertext always finds FIFO space.
//   clk, rst          : clock, synchronous active-high reset
//   s_valid/s_ready   : input word handshake, s_data MSB-first per group
//   s_is_key          : group type, sampled on word 0
//   blk_data, blk_key : registered plaintext / key to the cipher
//   ct_in             : cipher output, valid LAT cycles after issue
//   m_valid/m_ready   : output word handshake, m_data MSB-first
//   m_last            : 4th word of a ciphertext block
//   key_valid         : a key has been loaded since reset
//   busy              : anything in flight, buffered or partially moved
// -----------------------------------------------------------------------------
module aes_stream_if
  import aes_stream_pkg::*;
#(
  parameter int LAT   = 10,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_is_key,
  output logic [BLK_W-1:0]  blk_data,
  output logic [BLK_W-1:0]  blk_key,
  input  logic [BLK_W-1:0]  ct_in,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_last,
  output logic              key_valid,
  output logic              busy
);

  localparam int CW    = cred_w(DEPTH);
  localparam int ASM_W = BLK_W - WORD_W;

  word_idx_t        w_q, w_d;
  grp_e             grp_q, grp_d;
  logic             key_valid_q, key_valid_d;
  logic [CW-1:0]    cred_q, cred_d;
  logic [LAT-1:0]   vsr_q, vsr_d;
  word_idx_t        idx_q, idx_d;
  logic [ASM_W-1:0] asm_q, asm_d;
  logic [BLK_W-1:0] blk_data_q, blk_data_d;
  logic [BLK_W-1:0] blk_key_q, blk_key_d;

  logic             accept_s, issue_s, key_load_s;
  logic             hs_s, pop_s, cap_s;
  logic [BLK_W-1:0] head_s;
  logic             fifo_empty_s, fifo_full_s;

  assign blk_data  = blk_data_q;
  assign blk_key   = blk_key_q;
  assign key_valid = key_valid_q;
  assign busy      = (cred_q != {CW{1'b0}}) | (w_q != 2'd0) | (idx_q != 2'd0);

  // Input acceptance: data waits for a key, and a data block may only
  // complete when a FIFO slot is reserved for its ciphertext.
  always_comb begin
    s_ready = 1'b1;
    if (w_q == 2'd0) begin
      s_ready = s_is_key | key_valid_q;
    end else if ((w_q == LAST_WORD) && (grp_q == GRP_DATA)) begin
      s_ready = (cred_q < CW'(DEPTH));
    end else begin
      s_ready = 1'b1;
    end
  end

  // Packer: word assembly, key load and block issue.
  always_comb begin
    accept_s    = s_valid & s_ready;
    issue_s     = accept_s & (w_q == LAST_WORD) & (grp_q == GRP_DATA);
    key_load_s  = accept_s & (w_q == LAST_WORD) & (grp_q == GRP_KEY);
    w_d         = w_q;
    grp_d       = grp_q;
    asm_d       = asm_q;
    blk_data_d  = blk_data_q;
    blk_key_d   = blk_key_q;
    key_valid_d = key_valid_q;
    if (accept_s) begin
      w_d = w_q + 2'd1;
      if (w_q == 2'd0) begin
        grp_d = s_is_key ? GRP_KEY : GRP_DATA;
      end else begin
        grp_d = grp_q;
      end
      case (w_q)
        2'd0:    asm_d[ASM_W-1 -: WORD_W]        = s_data;
        2'd1:    asm_d[ASM_W-1-WORD_W -: WORD_W] = s_data;
        2'd2:    asm_d[WORD_W-1:0]               = s_data;
        default: asm_d = asm_q;
      endcase
    end else begin
      w_d = w_q;
    end
    // The last word is taken straight from the bus, so the block lands in
    // blk_key/blk_data on the accepting edge.
    if (key_load_s) begin
      blk_key_d   = {asm_q, s_data};
      key_valid_d = 1'b1;
    end else begin
      blk_key_d = blk_key_q;
    end
    if (issue_s) begin
      blk_data_d = {asm_q, s_data};
    end else begin
      blk_data_d = blk_data_q;
    end
  end

  // Back end: latency tracking, serialiser and credit accounting.
  always_comb begin
    cap_s   = vsr_q[LAT-1];
    vsr_d   = {vsr_q[LAT-2:0], issue_s};
    m_valid = ~fifo_empty_s;
    hs_s    = m_valid & m_ready;
    pop_s   = hs_s & (idx_q == LAST_WORD);
    m_last  = m_valid & (idx_q == LAST_WORD);
    if (hs_s) begin
      idx_d = idx_q + 2'd1;
    end else begin
      idx_d = idx_q;
    end
    case (idx_q)
      2'd0:    m_data = head_s[BLK_W-1 -: WORD_W];
      2'd1:    m_data = head_s[BLK_W-1-WORD_W -: WORD_W];
      2'd2:    m_data = head_s[BLK_W-1-2*WORD_W -: WORD_W];
      default: m_data = head_s[WORD_W-1:0];
    endcase
    case ({issue_s, pop_s})
      2'b10:   cred_d = cred_q + CW'(1);
      2'b01:   cred_d = cred_q - CW'(1);
      default: cred_d = cred_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q         <= 2'd0;
      grp_q       <= GRP_DATA;
      key_valid_q <= 1'b0;
      cred_q      <= {CW{1'b0}};
      vsr_q       <= {LAT{1'b0}};
      idx_q       <= 2'd0;
      asm_q       <= {ASM_W{1'b0}};
      blk_data_q  <= {BLK_W{1'b0}};
      blk_key_q   <= {BLK_W{1'b0}};
    end else begin
      w_q         <= w_d;
      grp_q       <= grp_d;
      key_valid_q <= key_valid_d;
      cred_q      <= cred_d;
      vsr_q       <= vsr_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      blk_data_q  <= blk_data_d;
      blk_key_q   <= blk_key_d;
    end
  end

  aes_blk_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cap_s),
    .data_i  (ct_in),
    .pop_i   (pop_s),
    .data_o  (head_s),
    .empty_o (fifo_empty_s),
    .full_o  (fifo_full_s)
  );

endmodule

// File: tb/tb_aes_stream_if.sv
// -----------------------------------------------------------------------------
// tb_aes_stream_if
// Directed bench for aes_stream_if. A stand-in cipher pipeline returns the
// FIPS-197 ciphertext for the FIPS key/plaintext pair and a simple keyed mix
// for anything else, LAT cycles after issue.
// -----------------------------------------------------------------------------
module tb_aes_stream_if;

  localparam int LAT   = 10;
  localparam int DEPTH = 4;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B    = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] PT_P     = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         s_is_key;
  logic [127:0] blk_data;
  logic [127:0] blk_key;
  logic [127:0] ct_in;
  logic         m_valid;
  logic         m_ready;
  logic [31:0]  m_data;
  logic         m_last;
  logic         key_valid;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [32:0] obs_q[$];
  logic [32:0] exp_q[$];
  int          obs_base   = 0;
  int          valid_cnt  = 0;
  int          stall_seen = 0;
  int          stall_bad  = 0;
  int          rdy_mode   = 0;
  int          allow_req  = 0;

  aes_stream_if #(
    .LAT   (LAT),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_is_key  (s_is_key),
    .blk_data  (blk_data),
    .blk_key   (blk_key),
    .ct_in     (ct_in),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .key_valid (key_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] ciph(input logic [127:0] pt, input logic [127:0] key);
    if (key == FIPS_KEY && pt == FIPS_PT) return FIPS_CT;
    return pt ^ {key[63:0], key[127:64]} ^ 128'h5a5a5a5a_c3c3c3c3_0f0f0f0f_96969696;
  endfunction

  function automatic logic [127:0] pt_n(input int n);
    return {32'h0100_0000 + 32'(n), 32'h0200_0000 + 32'(n),
            32'h0300_0000 + 32'(n), 32'h0400_0000 + 32'(n)};
  endfunction

  // Cipher stand-in: blk_data/blk_key registered at issue edge t produce
  // ct_in during the cycle ending at edge t+LAT.
  logic [127:0] pipe_q [LAT-1];
  always @(posedge clk) begin
    pipe_q[0] <= ciph(blk_data, blk_key);
    for (int k = 1; k < LAT - 1; k++) pipe_q[k] <= pipe_q[k-1];
  end
  assign ct_in = pipe_q[LAT-2];

  // Output consumer: drives m_ready just after each rising edge.
  initial begin
    int allow_used;
    allow_used = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: m_ready = 1'b1;
        1: m_ready = 1'b0;
        2: m_ready = 1'($urandom_range(0, 1));
        3: begin
          if (allow_used < allow_req && m_valid === 1'b1) begin
            m_ready = 1'b1;
            allow_used++;
          end else begin
            m_ready = 1'b0;
          end
        end
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: records handshaked words and stall stability.
  initial begin
    logic [32:0] prev_w;
    logic        prev_stall;
    logic        prev_rst;
    prev_w = 33'd0;
    prev_stall = 1'b0;
    prev_rst = 1'b1;
    forever begin
      @(negedge clk);
      if (prev_stall && !prev_rst) begin
        stall_seen++;
        if (m_valid !== 1'b1 || {m_last, m_data} !== prev_w) stall_bad++;
      end
      if (m_valid === 1'b1 && m_ready === 1'b1) obs_q.push_back({m_last, m_data});
      if (m_valid === 1'b1) valid_cnt++;
      prev_stall = (m_valid === 1'b1) && (m_ready === 1'b0);
      prev_w     = {m_last, m_data};
      prev_rst   = rst;
    end
  end

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic k, input int maxc, output logic ok);
    s_valid  = 1'b1;
    s_data   = d;
    s_is_key = k;
    ok       = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if (s_ready === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic send_group(input logic [127:0] v, input logic k, input int maxc, output logic ok);
    logic ok_w;
    ok = 1'b1;
    for (int w = 0; w < 4; w++) begin
      send_word(v[127-32*w -: 32], k, maxc, ok_w);
      ok = ok & ok_w;
    end
  endtask

  task automatic push_exp_blk(input logic [127:0] ct);
    for (int w = 0; w < 4; w++) exp_q.push_back({(w == 3), ct[127-32*w -: 32]});
  endtask

  task automatic wait_words(input int n, input int maxc);
    int c;
    c = 0;
    while ((obs_q.size() - obs_base) < n && c < maxc) begin
      @(posedge clk);
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic compare_obs(input string tag);
    int n;
    n = obs_q.size() - obs_base;
    check_eq({tag, "_count"}, 128'(n), 128'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      check_eq($sformatf("%s_w%0d", tag, i), 128'(obs_q[obs_base + i]), 128'(exp_q[i]));
    end
    obs_base = obs_q.size();
    exp_q.delete();
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int c;
    c = 0;
    while (busy !== 1'b0 && c < maxc) begin
      @(posedge clk);
      #1;
      c++;
    end
    check_eq({tag, "_idle"}, 128'(busy), 128'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         ok, all_ok;
    logic [127:0] v;
    int           lat_n, snap;

    s_valid  = 1'b0;
    s_data   = 32'd0;
    s_is_key = 1'b1;
    rst      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check_eq("rst_m_valid",   128'(m_valid),   128'(0));
    check_eq("rst_m_last",    128'(m_last),    128'(0));
    check_eq("rst_key_valid", 128'(key_valid), 128'(0));
    check_eq("rst_busy",      128'(busy),      128'(0));
    check_eq("rst_blk_data",  blk_data,        128'd0);
    check_eq("rst_blk_key",   blk_key,         128'd0);
    check_eq("rst_s_ready",   128'(s_ready),   128'(1));
    @(posedge clk);
    #1;

    // Data before any key is refused.
    v = FIPS_PT;
    s_is_key = 1'b0;
    s_data   = v[127:96];
    s_valid  = 1'b1;
    @(negedge clk);
    check_eq("nokey_s_ready", 128'(s_ready), 128'(0));
    send_word(v[127:96], 1'b0, 5, ok);
    check_eq("nokey_refused", 128'(ok), 128'(0));
    check_eq("nokey_busy", 128'(busy), 128'(0));
    @(posedge clk);
    #1;

    // FIPS-197 vector with latency measurement.
    send_group(FIPS_KEY, 1'b1, 5, ok);
    check_eq("fips_key_ok", 128'(ok), 128'(1));
    @(negedge clk);
    check_eq("fips_key_valid", 128'(key_valid), 128'(1));
    check_eq("fips_blk_key", blk_key, FIPS_KEY);
    @(posedge clk);
    #1;
    send_group(FIPS_PT, 1'b0, 5, ok);
    check_eq("fips_pt_ok", 128'(ok), 128'(1));
    check_eq("fips_blk_data", blk_data, FIPS_PT);
    lat_n = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (m_valid === 1'b1) begin
        lat_n = n;
        break;
      end
    end
    check_eq("fips_latency", 128'(lat_n), 128'(LAT));
    exp_q.push_back({1'b0, 32'h69c4e0d8});
    exp_q.push_back({1'b0, 32'h6a7b0430});
    exp_q.push_back({1'b0, 32'hd8cdb780});
    exp_q.push_back({1'b1, 32'h70b4c55a});
    wait_words(4, 60);
    compare_obs("fips");
    wait_idle("fips", 20);

    // Key change between back-to-back blocks.
    all_ok = 1'b1;
    send_group(KEY_A, 1'b1, 5, ok); all_ok = all_ok & ok;
    send_group(PT_P,  1'b0, 5, ok); all_ok = all_ok & ok;
    send_group(KEY_B, 1'b1, 5, ok); all_ok = all_ok & ok;
    send_group(PT_P,  1'b0, 5, ok); all_ok = all_ok & ok;
    check_eq("keychg_accept", 128'(all_ok), 128'(1));
    push_exp_blk(ciph(PT_P, KEY_A));
    push_exp_blk(ciph(PT_P, KEY_B));
    wait_words(8, 80);
    compare_obs("keychg");
    wait_idle("keychg", 20);

    // Backpressure: only DEPTH blocks may be outstanding.
    rdy_mode = 1;
    all_ok = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      send_group(pt_n(b), 1'b0, 5, ok);
      all_ok = all_ok & ok;
    end
    check_eq("bp_first4", 128'(all_ok), 128'(1));
    v = pt_n(5);
    all_ok = 1'b1;
    for (int w = 0; w < 3; w++) begin
      send_word(v[127-32*w -: 32], 1'b0, 5, ok);
      all_ok = all_ok & ok;
    end
    check_eq("bp_w012", 128'(all_ok), 128'(1));
    send_word(v[31:0], 1'b0, 40, ok);
    check_eq("bp_w3_refused", 128'(ok), 128'(0));
    check_eq("bp_fifo_held", 128'(m_valid), 128'(1));
    check_eq("bp_no_out", 128'(obs_q.size() - obs_base), 128'(0));
    check_eq("bp_busy", 128'(busy), 128'(1));
    rdy_mode = 0;
    send_word(v[31:0], 1'b0, 100, ok);
    check_eq("bp_w3_late", 128'(ok), 128'(1));
    send_group(pt_n(6), 1'b0, 100, ok);
    check_eq("bp_blk6", 128'(ok), 128'(1));
    for (int b = 1; b <= 6; b++) push_exp_blk(ciph(pt_n(b), KEY_B));
    wait_words(24, 200);
    compare_obs("bp");
    wait_idle("bp", 20);

    // Random output stalls.
    snap = stall_bad;
    lat_n = stall_seen;
    rdy_mode = 2;
    all_ok = 1'b1;
    for (int b = 7; b <= 9; b++) begin
      send_group(pt_n(b), 1'b0, 100, ok);
      all_ok = all_ok & ok;
      push_exp_blk(ciph(pt_n(b), KEY_B));
    end
    check_eq("stall_accept", 128'(all_ok), 128'(1));
    wait_words(12, 400);
    rdy_mode = 0;
    compare_obs("stall");
    check_eq("stall_stable", 128'(stall_bad - snap), 128'(0));
    check_eq("stall_exercised", 128'(stall_seen > lat_n), 128'(1));
    wait_idle("stall", 20);

    // Reset mid-flight: one block half sent, two in the pipeline.
    rdy_mode = 3;
    send_group(PT_P, 1'b0, 5, ok);
    for (int c = 0; c < 40 && m_valid !== 1'b1; c++) begin
      @(posedge clk);
      #1;
    end
    all_ok = ok;
    send_group(pt_n(10), 1'b0, 5, ok); all_ok = all_ok & ok;
    send_group(pt_n(11), 1'b0, 5, ok); all_ok = all_ok & ok;
    check_eq("mrst_accept", 128'(all_ok), 128'(1));
    allow_req = allow_req + 2;
    for (int c = 0; c < 40 && (obs_q.size() - obs_base) < 2; c++) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    check_eq("mrst_m_valid",   128'(m_valid),   128'(0));
    check_eq("mrst_key_valid", 128'(key_valid), 128'(0));
    check_eq("mrst_busy",      128'(busy),      128'(0));
    check_eq("mrst_blk_data",  blk_data,        128'd0);
    check_eq("mrst_partial",   128'(obs_q.size() - obs_base), 128'(2));
    obs_base = obs_q.size();
    rdy_mode = 0;
    snap = valid_cnt;
    repeat (30) @(posedge clk);
    #1;
    check_eq("mrst_quiet", 128'(valid_cnt - snap), 128'(0));
    send_word(32'h0badf00d, 1'b0, 5, ok);
    check_eq("mrst_nokey", 128'(ok), 128'(0));
    @(posedge clk);
    #1;
    send_group(KEY_A, 1'b1, 5, ok);  all_ok = ok;
    send_group(pt_n(12), 1'b0, 5, ok); all_ok = all_ok & ok;
    check_eq("mrst_restart", 128'(all_ok), 128'(1));
    push_exp_blk(ciph(pt_n(12), KEY_A));
    wait_words(4, 60);
    compare_obs("mrst_after");
    wait_idle("mrst", 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
